segment_descriptor_loader: RTL and testbench

Loads the six-entry segment descriptor cache consumed by the segmentation unit. On a segment register load it either synthesises a real-mode descriptor or fetches the 8-byte descriptor from the GDT/LDT over a 32-bit memory request port. It validates the selector against the table limit and the present bit, and writes the validated descriptor into the cache entry. It sits in the memory management unit between the execution unit (which issues segment loads) and the bus/cache interface, and drives the `segment_descriptor` array read by address translation.

---
 rtl/segment_descriptor_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_segment_descriptor_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_descriptor_loader.sv
// segment_descriptor_loader
//   Fills the six-entry segment descriptor cache (0=CS 1=SS 2=DS 3=ES 4=FS
//   5=GS). A real-mode load synthesises a flat 64 KiB descriptor from the
//   selector. A protected-mode load validates the selector against the
//   GDT/LDT limit, fetches the 8-byte descriptor as two 32-bit reads, checks
//   the present bit and caches it.
//
//   Optional feature macro: SEGMENT_ACCESSED_WRITEBACK_EN
//     When defined, a descriptor fetched with A=0 has its high dword written
//     back to memory with A set, and is cached with A=1. When undefined,
//     mem_req_write is tied to 0 and descriptors are cached exactly as read.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   load_valid/load_ready      segment load handshake (ready only in IDLE)
//   load_segment_index         target cache entry (6,7 -> limit fault)
//   load_selector              index[15:3], TI[2], RPL[1:0]
//   protected_mode             selects real/protected behaviour at acceptance
//   gdt_base/gdt_limit         global descriptor table base / inclusive limit
//   ldt_base/ldt_limit         local descriptor table base / inclusive limit
//   mem_req_*                  single-outstanding 32-bit memory request port
//   mem_rsp_valid/mem_rsp_data read data / write acknowledge
//   segment_descriptor         the six cached descriptors
//   done_valid                 one-cycle completion pulse
//   done_fault, fault_code     0=none 1=limit 2=null selector 3=not present
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a load; real-mode loads complete directly from here
// CHECK     | null-selector and table-limit validation
// READ_LO   | low dword read request held until accepted
// WAIT_LO   | waiting for low dword data
// READ_HI   | high dword read request held until accepted
// WAIT_HI   | waiting for high dword data
// EVAL      | present-bit check; cache or start accessed-bit writeback
// WRITEBACK | high dword write (A set) held until accepted
// WAIT_WB   | waiting for the write acknowledge
// DONE      | done_valid pulse, cache entry already updated

module segment_descriptor_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [2:0]  load_segment_index,
    input  logic [15:0] load_selector,
    input  logic        protected_mode,
    input  logic [31:0] gdt_base,
    input  logic [31:0] ldt_base,
    input  logic [31:0] gdt_limit,
    input  logic [31:0] ldt_limit,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_address,
    output logic        mem_req_write,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [63:0] segment_descriptor [6],
    output logic        done_valid,
    output logic        done_fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [3:0] {
        IDLE, CHECK, READ_LO, WAIT_LO, READ_HI, WAIT_HI,
        EVAL, WRITEBACK, WAIT_WB, DONE
    } state_t;

    state_t      state;
    logic [2:0]  seg_idx;
    logic        sel_null;
    logic [31:0] offset;
    logic [31:0] tbl_base;
    logic [31:0] tbl_limit;
    logic [31:0] desc_lo;
    logic [31:0] desc_hi;
    logic        wb_needed;

`ifdef SEGMENT_ACCESSED_WRITEBACK_EN
    assign wb_needed = ~desc_hi[8];
`else
    assign wb_needed     = 1'b0;
    assign mem_req_write = 1'b0;
    assign mem_req_wdata = 32'h0;
`endif

    // Flat 64 KiB segment at selector*16; CS gets an execute/read code type.
    function automatic logic [63:0] real_mode_desc(input logic [2:0] idx,
                                                   input logic [15:0] sel);
        logic [7:0] access;
        access = (idx == 3'd0) ? 8'h9B : 8'h93;
        return {8'h00, 4'h0, 4'h0, access, 4'h0, sel, 4'h0, 16'hFFFF};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            load_ready      <= 1'b0;
            seg_idx         <= 3'd0;
            sel_null        <= 1'b0;
            offset          <= 32'h0;
            tbl_base        <= 32'h0;
            tbl_limit       <= 32'h0;
            desc_lo         <= 32'h0;
            desc_hi         <= 32'h0;
            mem_req_valid   <= 1'b0;
            mem_req_address <= 32'h0;
`ifdef SEGMENT_ACCESSED_WRITEBACK_EN
            mem_req_write   <= 1'b0;
            mem_req_wdata   <= 32'h0;
`endif
            done_valid      <= 1'b0;
            done_fault      <= 1'b0;
            fault_code      <= 2'd0;
            for (int i = 0; i < 6; i++) segment_descriptor[i] <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    load_ready <= 1'b1;
                    if (load_valid && load_ready) begin
                        load_ready <= 1'b0;
                        seg_idx    <= load_segment_index;
                        sel_null   <= (load_selector[15:2] == 14'h0);
                        offset     <= {16'h0, load_selector[15:3], 3'b000};
                        tbl_base   <= load_selector[2] ? ldt_base  : gdt_base;
                        tbl_limit  <= load_selector[2] ? ldt_limit : gdt_limit;
                        if (protected_mode) begin
                            state <= CHECK;
                        end else begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                            if (load_segment_index > 3'd5) begin
                                done_fault <= 1'b1;
                                fault_code <= 2'd1;
                            end else begin
                                done_fault <= 1'b0;
                                fault_code <= 2'd0;
                                segment_descriptor[load_segment_index] <=
                                    real_mode_desc(load_segment_index, load_selector);
                            end
                        end
                    end
                end
                CHECK: begin
                    if (seg_idx > 3'd5) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_fault <= 1'b1;
                        fault_code <= 2'd1;
                    end else if (sel_null) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        if (seg_idx < 3'd2) begin
                            done_fault <= 1'b1;
                            fault_code <= 2'd2;
                        end else begin
                            // Null data-segment load is legal: entry becomes not-present.
                            done_fault <= 1'b0;
                            fault_code <= 2'd0;
                            segment_descriptor[seg_idx] <= 64'h0;
                        end
                    end else if (({1'b0, offset} + 33'd7) > {1'b0, tbl_limit}) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_fault <= 1'b1;
                        fault_code <= 2'd1;
                    end else begin
                        state           <= READ_LO;
                        mem_req_valid   <= 1'b1;
                        mem_req_address <= tbl_base + offset;
                    end
                end
                READ_LO: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (mem_rsp_valid) begin
                        desc_lo         <= mem_rsp_data;
                        mem_req_valid   <= 1'b1;
                        mem_req_address <= mem_req_address + 32'd4;
                        state           <= READ_HI;
                    end
                end
                READ_HI: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (mem_rsp_valid) begin
                        desc_hi <= mem_rsp_data;
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    if (!desc_hi[15]) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_fault <= 1'b1;
                        fault_code <= 2'd3;
                    end else if (wb_needed) begin
                        // Address still points at the high dword from READ_HI.
                        state         <= WRITEBACK;
                        mem_req_valid <= 1'b1;
`ifdef SEGMENT_ACCESSED_WRITEBACK_EN
                        mem_req_write <= 1'b1;
                        mem_req_wdata <= desc_hi | 32'h0000_0100;
`endif
                    end else begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_fault <= 1'b0;
                        fault_code <= 2'd0;
                        segment_descriptor[seg_idx] <= {desc_hi, desc_lo};
                    end
                end
                WRITEBACK: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
`ifdef SEGMENT_ACCESSED_WRITEBACK_EN
                        mem_req_write <= 1'b0;
`endif
                        state         <= WAIT_WB;
                    end
                end
                WAIT_WB: begin
                    if (mem_rsp_valid) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_fault <= 1'b0;
                        fault_code <= 2'd0;
                        segment_descriptor[seg_idx] <= {desc_hi | 32'h0000_0100, desc_lo};
                    end
                end
                DONE: begin
                    done_valid <= 1'b0;
                    done_fault <= 1'b0;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_descriptor_loader.sv
// Directed bench for segment_descriptor_loader. A small responder accepts
// requests (ready driven by the bench), logs them and returns the staged
// descriptor dword one cycle after each handshake.
module tb_segment_descriptor_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  load_segment_index;
    logic [15:0] load_selector;
    logic        protected_mode;
    logic [31:0] gdt_base, ldt_base, gdt_limit, ldt_limit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_address;
    logic        mem_req_write;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [63:0] seg_desc [6];
    logic        done_valid;
    logic        done_fault;
    logic [1:0]  fault_code;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] desc_lo, desc_hi;
    logic        block_hi;
    int          n_req;
    logic [31:0] req_addr  [16];
    logic        req_write [16];
    logic [31:0] req_wdata [16];
    logic        pend;
    logic [31:0] pend_data;

    int          lat;
    logic        flt;
    logic [1:0]  code;
    logic        saw_done;

    segment_descriptor_loader dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .load_valid         (load_valid),
        .load_ready         (load_ready),
        .load_segment_index (load_segment_index),
        .load_selector      (load_selector),
        .protected_mode     (protected_mode),
        .gdt_base           (gdt_base),
        .ldt_base           (ldt_base),
        .gdt_limit          (gdt_limit),
        .ldt_limit          (ldt_limit),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_address    (mem_req_address),
        .mem_req_write      (mem_req_write),
        .mem_req_wdata      (mem_req_wdata),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_data       (mem_rsp_data),
        .segment_descriptor (seg_desc),
        .done_valid         (done_valid),
        .done_fault         (done_fault),
        .fault_code         (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: works on the falling edge; ready is only changed
    // by the main sequence just after a rising edge.
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        pend          = 1'b0;
        pend_data     = 32'h0;
        n_req         = 0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = pend;
            mem_rsp_data  = pend ? pend_data : 32'h0;
            pend          = 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                if (n_req < 16) begin
                    req_addr[n_req]  = mem_req_address;
                    req_write[n_req] = mem_req_write;
                    req_wdata[n_req] = mem_req_wdata;
                end
                n_req++;
                pend      = !(block_hi && mem_req_address[2]);
                pend_data = mem_req_address[2] ? desc_hi : desc_lo;
            end
        end
    end

    // Issue one load at a falling edge and report the cycle (counted from
    // acceptance) on which done_valid is seen, or -1 on timeout.
    task automatic do_load(input logic [2:0] idx, input logic [15:0] sel, input logic pm,
                           output int lat_o, output logic flt_o, output logic [1:0] code_o);
        @(negedge clk);
        check("load_ready_before_load", 64'(load_ready), 64'd1);
        n_req              = 0;
        load_valid         = 1'b1;
        load_segment_index = idx;
        load_selector      = sel;
        protected_mode     = pm;
        lat_o  = -1;
        flt_o  = 1'bx;
        code_o = 2'bxx;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                load_valid     = 1'b0;
                load_selector  = 16'hDEAD;
                protected_mode = ~pm;
            end
            if (done_valid) begin
                lat_o  = c;
                flt_o  = done_fault;
                code_o = fault_code;
                break;
            end
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        load_valid         = 1'b0;
        load_segment_index = 3'd0;
        load_selector      = 16'h0;
        protected_mode     = 1'b0;
        gdt_base           = 32'h0001_0000;
        gdt_limit          = 32'h0000_FFFF;
        ldt_base           = 32'h0002_0000;
        ldt_limit          = 32'h0000_00FF;
        mem_req_ready      = 1'b1;
        block_hi           = 1'b0;
        desc_lo            = 32'h0000_FFFF;
        desc_hi            = 32'h00CF_9300;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_load_ready", 64'(load_ready), 64'd1);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_req_addr", 64'(mem_req_address), 64'd0);
        check("rst_req_write", 64'(mem_req_write), 64'd0);
        check("rst_done", 64'({done_valid, done_fault, fault_code}), 64'd0);
        for (int i = 0; i < 6; i++) check("rst_entry", seg_desc[i], 64'h0);

        // Real-mode DS load
        do_load(3'd2, 16'h1234, 1'b0, lat, flt, code);
        check("real_ds_lat", 64'(lat), 64'd1);
        check("real_ds_fault", 64'(flt), 64'd0);
        check("real_ds_entry", seg_desc[2], 64'h0000_9301_2340_FFFF);
        check("real_ds_cs_untouched", seg_desc[0], 64'h0);
        @(negedge clk);
        check("done_one_cycle", 64'(done_valid), 64'd0);

        // Real-mode CS uses code access byte
        do_load(3'd0, 16'hF000, 1'b0, lat, flt, code);
        check("real_cs_entry", seg_desc[0], 64'h0000_9B0F_0000_FFFF);

        // Protected GDT load, A already set
        do_load(3'd2, 16'h0010, 1'b1, lat, flt, code);
        check("gdt_lat", 64'(lat), 64'd7);
        check("gdt_fault", 64'(flt), 64'd0);
        check("gdt_entry", seg_desc[2], 64'h00CF_9300_0000_FFFF);
        check("gdt_nreq", 64'(n_req), 64'd2);
        check("gdt_addr_lo", 64'(req_addr[0]), 64'h0001_0010);
        check("gdt_addr_hi", 64'(req_addr[1]), 64'h0001_0014);
        check("gdt_reads", 64'({req_write[0], req_write[1]}), 64'd0);

        // Protected GDT load with A clear into ES
        desc_hi = 32'h00CF_9200;
        do_load(3'd3, 16'h0010, 1'b1, lat, flt, code);
`ifdef SEGMENT_ACCESSED_WRITEBACK_EN
        check("wb_lat", 64'(lat), 64'd9);
        check("wb_nreq", 64'(n_req), 64'd3);
        check("wb_addr", 64'(req_addr[2]), 64'h0001_0014);
        check("wb_write", 64'(req_write[2]), 64'd1);
        check("wb_wdata", 64'(req_wdata[2]), 64'h00CF_9300);
        check("wb_entry", seg_desc[3], 64'h00CF_9300_0000_FFFF);
`else
        check("nowb_lat", 64'(lat), 64'd7);
        check("nowb_nreq", 64'(n_req), 64'd2);
        check("nowb_entry", seg_desc[3], 64'h00CF_9200_0000_FFFF);
`endif
        check("a_clear_fault", 64'(flt), 64'd0);

        // Limit fault: offset 24 + 7 > 0x17
        desc_hi   = 32'h00CF_9300;
        gdt_limit = 32'h0000_0017;
        do_load(3'd4, 16'h0018, 1'b1, lat, flt, code);
        check("limit_lat", 64'(lat), 64'd2);
        check("limit_code", 64'({flt, code}), 64'({1'b1, 2'd1}));
        check("limit_nreq", 64'(n_req), 64'd0);
        check("limit_entry", seg_desc[4], 64'h0);

        // Limit boundary: offset 16 + 7 == 0x17 is inside
        do_load(3'd4, 16'h0010, 1'b1, lat, flt, code);
        check("limit_edge_lat", 64'(lat), 64'd7);
        check("limit_edge_entry", seg_desc[4], 64'h00CF_9300_0000_FFFF);
        gdt_limit = 32'h0000_FFFF;

        // Target index 6 faults as limit
        do_load(3'd6, 16'h0010, 1'b1, lat, flt, code);
        check("idx6_code", 64'({lat[3:0], flt, code}), 64'({4'd2, 1'b1, 2'd1}));

        // Null selector into SS keeps previous real-mode entry
        do_load(3'd1, 16'h0040, 1'b0, lat, flt, code);
        do_load(3'd1, 16'h0003, 1'b1, lat, flt, code);
        check("null_ss_lat", 64'(lat), 64'd2);
        check("null_ss_code", 64'({flt, code}), 64'({1'b1, 2'd2}));
        check("null_ss_entry", seg_desc[1], 64'h0000_9300_0400_FFFF);

        // Null selector into ES clears entry without fault
        do_load(3'd3, 16'h0000, 1'b1, lat, flt, code);
        check("null_es_lat", 64'(lat), 64'd2);
        check("null_es_fault", 64'(flt), 64'd0);
        check("null_es_entry", seg_desc[3], 64'h0);

        // Not-present descriptor keeps DS
        desc_hi = 32'h0000_1300;
        do_load(3'd2, 16'h0010, 1'b1, lat, flt, code);
        check("np_lat", 64'(lat), 64'd7);
        check("np_code", 64'({flt, code}), 64'({1'b1, 2'd3}));
        check("np_entry", seg_desc[2], 64'h00CF_9300_0000_FFFF);

        // LDT load into GS
        desc_lo = 32'h1234_5678;
        desc_hi = 32'hAB40_F300;
        do_load(3'd5, 16'h000C, 1'b1, lat, flt, code);
        check("ldt_lat", 64'(lat), 64'd7);
        check("ldt_addr_lo", 64'(req_addr[0]), 64'h0002_0008);
        check("ldt_addr_hi", 64'(req_addr[1]), 64'h0002_000C);
        check("ldt_entry", seg_desc[5], 64'hAB40_F300_1234_5678);

        // Stall then reset while in WAIT_HI
        desc_hi = 32'h00CF_9300;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        block_hi = 1'b1;
        saw_done = 1'b0;
        @(negedge clk);
        n_req              = 0;
        load_valid         = 1'b1;
        load_segment_index = 3'd2;
        load_selector      = 16'h0010;
        protected_mode     = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw_done |= done_valid;
        end
        check("stall_req_valid", 64'(mem_req_valid), 64'd1);
        check("stall_req_addr", 64'(mem_req_address), 64'h0001_0010);
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            saw_done |= done_valid;
        end
        check("stall_nreq", 64'(n_req), 64'd2);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) check("abort_entry", seg_desc[i], 64'h0);
        repeat (2) begin
            @(negedge clk);
            saw_done |= done_valid;
        end
        rst_n    = 1'b1;
        block_hi = 1'b0;
        @(negedge clk);
        saw_done |= done_valid;
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_load_ready", 64'(load_ready), 64'd1);
        check("abort_req_valid", 64'(mem_req_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
